// File: rtl/wr_ptr_gray_full_if.sv
// Write-side pointer bus between the write client (master) and wr_ptr_gray_full (slave).
// Carries the write request, the synchronised read pointer, and the flags and level.
interface wr_ptr_gray_full_if #(
  parameter int unsigned pointer_width = 4
);
  logic                     winc;
  logic [pointer_width-1:0] wq2_rptr;
  logic [pointer_width-2:0] waddr;
  logic [pointer_width-1:0] gray_wptr;
  logic                     wfull;
  logic                     walmost_full;
  logic [pointer_width-1:0] wlevel;
  logic                     wovf;

  modport master (
    output winc,
    output wq2_rptr,
    input  waddr,
    input  gray_wptr,
    input  wfull,
    input  walmost_full,
    input  wlevel,
    input  wovf
  );

  modport slave (
    input  winc,
    input  wq2_rptr,
    output waddr,
    output gray_wptr,
    output wfull,
    output walmost_full,
    output wlevel,
    output wovf
  );
endinterface

// File: rtl/wr_ptr_gray_full.sv
// Async-FIFO write pointer stage: binary/Gray write pointer, full, almost-full and level.
// Define FIFO_WOVF_EN to build the sticky overflow flag; otherwise wovf is tied low.
module wr_ptr_gray_full #(
  parameter int unsigned pointer_width = 4,
  parameter int unsigned AF_MARGIN     = 2
) (
  input logic               wclk,
  input logic               wrst_n,
  wr_ptr_gray_full_if.slave bus
);

  localparam int unsigned Depth = 2 ** (pointer_width - 1);
  localparam logic [pointer_width-1:0] AfThresh = pointer_width'(Depth - AF_MARGIN);

  logic [pointer_width-1:0] r_wbin;
  logic [pointer_width-1:0] r_gray_wptr;
  logic                     r_wfull;
  logic                     r_walmost_full;
  logic [pointer_width-1:0] r_wlevel;

  logic                     w_wacc;
  logic [pointer_width-1:0] w_wbin_next;
  logic [pointer_width-1:0] w_wgray_next;
  logic [pointer_width-1:0] w_rbin_sync;
  logic [pointer_width-1:0] w_full_ptr;
  logic [pointer_width-1:0] w_level_next;

  always_comb begin
    w_wacc       = bus.winc & ~r_wfull;
    w_wbin_next  = r_wbin + pointer_width'(w_wacc);
    w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;
    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    for (int i = 0; i < int'(pointer_width); i++) begin
      w_rbin_sync[i] = ^(bus.wq2_rptr >> i);
    end
    // Full when the write pointer is one lap ahead: top two Gray bits inverted.
    w_full_ptr   = {~bus.wq2_rptr[pointer_width-1:pointer_width-2],
                    bus.wq2_rptr[pointer_width-3:0]};
    w_level_next = w_wbin_next - w_rbin_sync;
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      r_wbin         <= '0;
      r_gray_wptr    <= '0;
      r_wfull        <= 1'b0;
      r_walmost_full <= 1'b0;
      r_wlevel       <= '0;
    end else begin
      r_wbin         <= w_wbin_next;
      r_gray_wptr    <= w_wgray_next;
      r_wfull        <= (w_wgray_next == w_full_ptr);
      r_walmost_full <= (w_level_next >= AfThresh);
      r_wlevel       <= w_level_next;
    end
  end

`ifdef FIFO_WOVF_EN
  logic r_wovf;

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      r_wovf <= 1'b0;
    end else begin
      r_wovf <= r_wovf | (bus.winc & r_wfull);
    end
  end

  assign bus.wovf = r_wovf;
`else
  assign bus.wovf = 1'b0;
`endif

  assign bus.waddr        = r_wbin[pointer_width-2:0];
  assign bus.gray_wptr    = r_gray_wptr;
  assign bus.wfull        = r_wfull;
  assign bus.walmost_full = r_walmost_full;
  assign bus.wlevel       = r_wlevel;

endmodule

// File: tb/tb_wr_ptr_gray_full.sv
// Bench for wr_ptr_gray_full: directed and random writes against a count-based FIFO model.
// Read progress is modelled as an integer read count lagging the write count.
module tb_wr_ptr_gray_full;

  localparam int unsigned PW = 4;
`ifdef FIFO_WOVF_EN
  localparam bit OvfEn = 1'b1;
`else
  localparam bit OvfEn = 1'b0;
`endif

  logic wclk   = 1'b0;
  logic wrst_n = 1'b0;

  wr_ptr_gray_full_if #(.pointer_width(PW)) bus ();

  wr_ptr_gray_full #(
    .pointer_width(PW),
    .AF_MARGIN    (2)
  ) dut (
    .wclk  (wclk),
    .wrst_n(wrst_n),
    .bus   (bus)
  );

  always #5 wclk = ~wclk;

  int total = 0;
  int bad   = 0;
  int wcount;   // total writes accepted since reset
  int rcnt;     // total reads the write domain has seen
  int m_level;
  bit m_full;
  bit m_ovf;
  int whist[$];

  function automatic logic [3:0] gray_of(input int n);
    logic [3:0] b;
    b = 4'(n);
    return b ^ (b >> 1);
  endfunction

  function automatic int lag2();
    if (whist.size() >= 2) return whist[whist.size()-2];
    return rcnt;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".waddr"}, 32'(bus.waddr), 32'(wcount % 8));
    chk({tag, ".gray"}, 32'(bus.gray_wptr), 32'(gray_of(wcount)));
    chk({tag, ".wfull"}, 32'(bus.wfull), 32'(m_full));
    chk({tag, ".afull"}, 32'(bus.walmost_full), 32'(m_level >= 6));
    chk({tag, ".wlevel"}, 32'(bus.wlevel), 32'(m_level));
    chk({tag, ".wovf"}, 32'(bus.wovf), 32'(OvfEn & m_ovf));
  endtask

  task automatic step(input string tag, input bit inc, input int rnext);
    bus.winc     = inc;
    rcnt         = rnext;
    bus.wq2_rptr = gray_of(rnext);
    if (inc && m_full) m_ovf = 1'b1;
    if (inc && !m_full) wcount++;
    m_level = wcount - rcnt;
    m_full  = (m_level == 8);
    whist.push_back(wcount);
    @(posedge wclk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    wrst_n       = 1'b0;
    bus.winc     = 1'b1;
    bus.wq2_rptr = '0;
    @(posedge wclk);
    #1;
    wrst_n   = 1'b1;
    bus.winc = 1'b0;
    wcount   = 0;
    rcnt     = 0;
    m_level  = 0;
    m_full   = 1'b0;
    m_ovf    = 1'b0;
    whist.delete();
    check_all("reset");
  endtask

  initial begin
    logic [3:0] prev_gray;
    int         prev_w;
    int         rn;

    bus.winc     = 1'b0;
    bus.wq2_rptr = '0;
    do_reset();

    // Random writes, then reset mid-operation.
    for (int i = 0; i < 5; i++) step("prefill", 1'($urandom_range(0, 1)), 0);
    do_reset();
    for (int i = 0; i < 3; i++) step("prefill2", 1'b1, 0);
    // A low pulse between edges must not reset anything.
    #1 wrst_n = 1'b0;
    #2 wrst_n = 1'b1;
    check_all("glitch");
    do_reset();

    // Fill to full, then one ignored write.
    for (int i = 0; i < 8; i++) step("fill", 1'b1, 0);
    chk("fill.gray1100", 32'(bus.gray_wptr), 32'h0000_000c);
    step("fill9", 1'b1, 0);
    chk("fill9.gray1100", 32'(bus.gray_wptr), 32'h0000_000c);

    // Release by one read, refill.
    step("release", 1'b0, 1);
    step("refill", 1'b1, 1);
    chk("refill.gray1101", 32'(bus.gray_wptr), 32'h0000_000d);
    step("drop", 1'b0, 3);
    step("drop2", 1'b0, 5);
    do_reset();

    // Almost-full threshold.
    for (int i = 0; i < 5; i++) step("af5", 1'b1, 0);
    step("af6", 1'b1, 0);
    do_reset();

    // Wrap with read pointer two cycles behind: one Gray bit per accept.
    for (int i = 0; i < 20; i++) begin
      prev_gray = bus.gray_wptr;
      prev_w    = wcount;
      step("wrap", 1'b1, lag2());
      if (wcount != prev_w) chk("wrap.onebit", 32'($countones(prev_gray ^ bus.gray_wptr)), 32'd1);
    end
    chk("wrap.count", 32'(wcount), 32'd20);
    do_reset();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rn = rcnt;
      if ($urandom_range(0, 3) != 0 && rcnt < lag2()) rn = rcnt + 1;
      step("rand", 1'($urandom_range(0, 2) != 0), rn);
    end
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
